// File: rtl/text_fb_ctrl.sv
// CPU-side write controller for a text-mode character RAM with circular top-of-screen scrolling.
// Latency: WRITE lands one cycle after acceptance; fills write one address per cycle from T+1.
// Backpressure: cmd_ready is low while a clear/scroll fill is in progress, and high again one cycle after its last write.
module text_fb_ctrl #(
    parameter int COLS   = 40,
    parameter int ROWS   = 25,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int FILL   = 0
) (
    input  logic                     cpu_clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [$clog2(ROWS)-1:0]  cmd_row,
    input  logic [$clog2(COLS)-1:0]  cmd_col,
    input  logic [DATA_W-1:0]        cmd_data,
    output logic                     ram_we,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_data,
    output logic [ADDR_W-1:0]        top_addr,
    output logic                     top_tgl,
    output logic                     err
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int N  = COLS * ROWS;

    localparam logic [ADDR_W:0]   N_W    = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0]   COLS_W = (ADDR_W+1)'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
    localparam logic [RW:0]       ROWS_L = (RW+1)'(ROWS);
    localparam logic [CW:0]       COLS_L = (CW+1)'(COLS);
    localparam logic [DATA_W-1:0] FILL_D = DATA_W'(FILL);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CLS   = 2'b01;
    localparam logic [1:0] OP_SCRL  = 2'b10;
    localparam logic [1:0] OP_CLL   = 2'b11;

    typedef enum logic {S_IDLE, S_FILL} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:0] fill_addr;
    logic [ADDR_W:0]   fill_cnt, fill_len;

    logic [ADDR_W:0]   row_off, map_sum, line_sum, scrl_sum;
    logic [ADDR_W:0]   map_wrap, line_wrap, scrl_wrap;
    logic              accept, bad_row, bad_col, reject;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_A) ? '0 : a + 1'b1;
    endfunction

    // Operands are each < N, so one conditional subtract of N reduces the sum mod N.
    always_comb begin
        row_off   = (ADDR_W+1)'(cmd_row) * COLS_W;
        line_sum  = {1'b0, top_addr} + row_off;
        map_sum   = line_sum + (ADDR_W+1)'(cmd_col);
        scrl_sum  = {1'b0, top_addr} + COLS_W;
        map_wrap  = (map_sum  >= N_W) ? map_sum  - N_W : map_sum;
        line_wrap = (line_sum >= N_W) ? line_sum - N_W : line_sum;
        scrl_wrap = (scrl_sum >= N_W) ? scrl_sum - N_W : scrl_sum;
        bad_row   = {1'b0, cmd_row} >= ROWS_L;
        bad_col   = {1'b0, cmd_col} >= COLS_L;
        accept    = cmd_valid & cmd_ready;
        reject    = ((cmd_op == OP_WRITE) & (bad_row | bad_col)) |
                    ((cmd_op == OP_CLL) & bad_row);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && !reject && cmd_op != OP_WRITE) state_d = S_FILL;
            S_FILL: if (fill_cnt == fill_len) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Acceptance issues the first write itself; FILL supplies writes 1..L-1 and then one drain cycle.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            cmd_ready <= 1'b1;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            top_addr  <= '0;
            top_tgl   <= 1'b0;
            err       <= 1'b0;
            fill_addr <= '0;
            fill_cnt  <= '0;
            fill_len  <= '0;
        end else begin
            ram_we    <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= (state_d == S_IDLE);
            if (state_q == S_IDLE && accept) begin
                if (reject) begin
                    err <= 1'b1;
                end else begin
                    ram_we   <= 1'b1;
                    ram_data <= FILL_D;
                    fill_cnt <= (ADDR_W+1)'(1);
                    fill_len <= COLS_W;
                    case (cmd_op)
                        OP_WRITE: begin
                            ram_addr <= map_wrap[ADDR_W-1:0];
                            ram_data <= cmd_data;
                        end
                        OP_CLS: begin
                            ram_addr  <= '0;
                            fill_addr <= wrap_inc('0);
                            fill_len  <= N_W;
                            if (top_addr != '0) begin
                                top_addr <= '0;
                                top_tgl  <= ~top_tgl;
                            end
                        end
                        OP_SCRL: begin
                            ram_addr  <= top_addr;
                            fill_addr <= wrap_inc(top_addr);
                            top_addr  <= scrl_wrap[ADDR_W-1:0];
                            top_tgl   <= ~top_tgl;
                        end
                        default: begin
                            ram_addr  <= line_wrap[ADDR_W-1:0];
                            fill_addr <= wrap_inc(line_wrap[ADDR_W-1:0]);
                        end
                    endcase
                end
            end else if (state_q == S_FILL && fill_cnt != fill_len) begin
                ram_we    <= 1'b1;
                ram_addr  <= fill_addr;
                ram_data  <= FILL_D;
                fill_addr <= wrap_inc(fill_addr);
                fill_cnt  <= fill_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_text_fb_ctrl.sv
// Directed bench for text_fb_ctrl at the default 40x25 geometry; expected values are hand-derived.
module tb_text_fb_ctrl;
    localparam int N = 1000;

    logic       cpu_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op   = 2'b00;
    logic [4:0] cmd_row  = '0;
    logic [5:0] cmd_col  = '0;
    logic [7:0] cmd_data = '0;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic [7:0] ram_data;
    logic [9:0] top_addr;
    logic       top_tgl;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int bad_w;
    int exp_tgl;
    int old_top;

    always #5 cpu_clk = ~cpu_clk;

    text_fb_ctrl dut (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_row  (cmd_row),
        .cmd_col  (cmd_col),
        .cmd_data (cmd_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .top_addr (top_addr),
        .top_tgl  (top_tgl),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one command; returns at accepting edge + 1, i.e. in the T+1 sample window.
    task automatic issue(input logic [1:0] op, input int row, input int col, input int data);
        int waited = 0;
        @(negedge cpu_clk);
        while (!cmd_ready && waited < 2000) begin
            @(negedge cpu_clk);
            waited++;
        end
        if (waited >= 2000) chk("ready_timeout", 32'(waited), 0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row   = 5'(row);
        cmd_col   = 6'(col);
        cmd_data  = 8'(data);
        @(posedge cpu_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Observe L consecutive fill writes of 0 starting at physical base, with cmd_ready low throughout.
    task automatic watch_fill(input int base, input int len, output int bad);
        bad = 0;
        for (int k = 0; k < len; k++) begin
            if (!(ram_we === 1'b1 && int'(ram_addr) == (base + k) % N &&
                  ram_data === 8'h00 && cmd_ready === 1'b0)) bad++;
            @(posedge cpu_clk);
            #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge cpu_clk);
        #1;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_we",    32'(ram_we),    0);
        chk("rst_addr",  32'(ram_addr),  0);
        chk("rst_data",  32'(ram_data),  0);
        chk("rst_top",   32'(top_addr),  0);
        chk("rst_tgl",   32'(top_tgl),   0);
        chk("rst_err",   32'(err),       0);
        reset = 1'b0;
        exp_tgl = 0;

        issue(2'b00, 0, 0, 8'h41);
        chk("wr0_we",    32'(ram_we),    1);
        chk("wr0_addr",  32'(ram_addr),  0);
        chk("wr0_data",  32'(ram_data),  32'h41);
        chk("wr0_ready", 32'(cmd_ready), 1);
        @(posedge cpu_clk); #1;
        chk("wr0_we_off", 32'(ram_we), 0);
        issue(2'b00, 24, 39, 8'h5A);
        chk("wr_last_addr", 32'(ram_addr), 999);
        chk("wr_last_data", 32'(ram_data), 32'h5A);

        issue(2'b01, 0, 0, 0);
        chk("cls_tgl_same", 32'(top_tgl), 0);
        watch_fill(0, 1000, bad_w);
        chk("cls_writes", 32'(bad_w), 0);
        chk("cls_we_end", 32'(ram_we), 0);
        chk("cls_ready_end", 32'(cmd_ready), 1);

        issue(2'b10, 0, 0, 0);
        exp_tgl ^= 1;
        chk("scr1_top", 32'(top_addr), 40);
        chk("scr1_tgl", 32'(top_tgl), 32'(exp_tgl));
        watch_fill(0, 40, bad_w);
        chk("scr1_writes", 32'(bad_w), 0);
        chk("scr1_ready_end", 32'(cmd_ready), 1);
        issue(2'b00, 24, 0, 8'h33);
        chk("scr1_wr_addr", 32'(ram_addr), 0);

        // Scrolls 2..24 take top to 960.
        for (int i = 0; i < 23; i++) begin
            old_top = 40 * (i + 1);
            issue(2'b10, 0, 0, 0);
            exp_tgl ^= 1;
            chk("scr_top", 32'(top_addr), 32'(old_top + 40));
            watch_fill(old_top, 40, bad_w);
            chk("scr_writes", 32'(bad_w), 0);
        end
        chk("scr_tgl_24", 32'(top_tgl), 32'(exp_tgl));

        issue(2'b11, 1, 0, 0);
        chk("cll_top_hold", 32'(top_addr), 960);
        watch_fill(0, 40, bad_w);
        chk("cll_wrap_writes", 32'(bad_w), 0);
        issue(2'b11, 24, 0, 0);
        watch_fill(920, 40, bad_w);
        chk("cll_r24_writes", 32'(bad_w), 0);

        issue(2'b10, 0, 0, 0);
        exp_tgl ^= 1;
        chk("scr25_top", 32'(top_addr), 0);
        chk("scr25_tgl", 32'(top_tgl), 32'(exp_tgl));
        watch_fill(960, 40, bad_w);
        chk("scr25_writes", 32'(bad_w), 0);

        issue(2'b00, 25, 0, 8'h11);
        chk("err_row", 32'(err), 1);
        chk("err_row_we", 32'(ram_we), 0);
        chk("err_row_top", 32'(top_addr), 0);
        chk("err_row_ready", 32'(cmd_ready), 1);
        @(posedge cpu_clk); #1;
        chk("err_pulse_end", 32'(err), 0);
        issue(2'b00, 3, 40, 8'h11);
        chk("err_col", 32'(err), 1);
        chk("err_col_we", 32'(ram_we), 0);
        issue(2'b11, 31, 0, 0);
        chk("err_cll", 32'(err), 1);
        chk("err_cll_ready", 32'(cmd_ready), 1);
        chk("err_cll_we", 32'(ram_we), 0);

        issue(2'b10, 0, 0, 0);
        exp_tgl ^= 1;
        watch_fill(0, 40, bad_w);
        issue(2'b01, 0, 0, 0);
        exp_tgl ^= 1;
        chk("cls_top_reset", 32'(top_addr), 0);
        chk("cls_tgl_flip", 32'(top_tgl), 32'(exp_tgl));
        watch_fill(0, 499, bad_w);
        chk("cls2_first499", 32'(bad_w), 0);
        chk("cls2_w500_addr", 32'(ram_addr), 499);
        reset = 1'b1;
        @(posedge cpu_clk); #1;
        chk("mid_rst_we", 32'(ram_we), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        chk("mid_rst_top", 32'(top_addr), 0);
        chk("mid_rst_tgl", 32'(top_tgl), 0);
        reset = 1'b0;
        bad_w = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge cpu_clk); #1;
            if (ram_we !== 1'b0) bad_w++;
        end
        chk("mid_rst_no_writes", 32'(bad_w), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
